npc_multicycle_core: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle NPC top.
- Executes the RV32I subset with an internal register file.
- Fetches instructions and accesses data memory over valid/ready request plus valid response channels, instead of a combinational inst input.
- Halts on EBREAK or on an illegal/misaligned event, and exposes halt status to the simulation harness.

---
 rtl/npc_multicycle_core_if.sv | 38 +++
 rtl/npc_multicycle_core.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_npc_multicycle_core.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/npc_multicycle_core_if.sv
// ============================================================================
// Module   : npc_multicycle_core_if
// Purpose  : Instruction and data memory channels for npc_multicycle_core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface npc_multicycle_core_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;

  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rdata,
    output dmem_req_valid, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rdata,
    input  dmem_req_valid, dmem_we, dmem_addr, dmem_wdata,
    output dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/npc_multicycle_core.sv
// ============================================================================
// Module   : npc_multicycle_core
// Purpose  : Multi-cycle RV32I/RV32E core with handshaked fetch and LW/SW.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module npc_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          NREGS    = 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  npc_multicycle_core_if.master        bus,
  output logic [31:0]                  pc,
  output logic                         retire,
  output logic                         halted,
  output logic                         illegal,
  output logic [31:0]                  halt_code
);

  localparam int                RIDX_W    = $clog2(NREGS);
  localparam logic              OOB_CHECK = (NREGS < 32);
  localparam logic [RIDX_W-1:0] X10_IDX   = RIDX_W'(10);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_WAIT_I = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WAIT_D = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] regs_q [NREGS];
  logic        retire_q;
  logic        halted_q;
  logic        illegal_q;
  logic [31:0] halt_code_q;
  logic        imem_req_valid_q;
  logic        dmem_req_valid_q;
  logic        dmem_we_q;
  logic [31:0] dmem_addr_q;
  logic [31:0] dmem_wdata_q;

  // Instruction fields and immediates
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, pc_plus4;

  assign opcode   = ir_q[6:0];
  assign rd       = ir_q[11:7];
  assign funct3   = ir_q[14:12];
  assign rs1      = ir_q[19:15];
  assign rs2      = ir_q[24:20];
  assign funct7   = ir_q[31:25];
  assign imm_i    = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s    = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b    = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u    = {ir_q[31:12], 12'b0};
  assign imm_j    = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign pc_plus4 = pc_q + 32'd4;

  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1[RIDX_W-1:0]];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2[RIDX_W-1:0]];

  logic [31:0] alu_b, alu_res;
  logic        use_rd, use_rs1, use_rs2, dec_illegal;
  logic        wr_en, is_mem, mem_we, is_ebreak, taken;
  logic [31:0] wr_data, next_pc, mem_addr;
  logic        exec_illegal;

  always_comb begin
    alu_b = (opcode == OPC_OP) ? rs2_val : imm_i;
    case (funct3)
      3'd0:    alu_res = (opcode == OPC_OP && funct7[5]) ? rs1_val - alu_b : rs1_val + alu_b;
      3'd1:    alu_res = rs1_val << alu_b[4:0];
      3'd2:    alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      3'd3:    alu_res = {31'd0, rs1_val < alu_b};
      3'd4:    alu_res = rs1_val ^ alu_b;
      3'd5:    alu_res = funct7[5] ? $unsigned($signed(rs1_val) >>> alu_b[4:0])
                                   : rs1_val >> alu_b[4:0];
      3'd6:    alu_res = rs1_val | alu_b;
      default: alu_res = rs1_val & alu_b;
    endcase
  end

  always_comb begin
    use_rd      = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    dec_illegal = 1'b0;
    wr_en       = 1'b0;
    wr_data     = alu_res;
    next_pc     = pc_plus4;
    is_mem      = 1'b0;
    mem_we      = 1'b0;
    is_ebreak   = 1'b0;
    taken       = 1'b0;
    mem_addr    = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    case (opcode)
      OPC_LUI: begin
        use_rd  = 1'b1;
        wr_en   = 1'b1;
        wr_data = imm_u;
      end
      OPC_AUIPC: begin
        use_rd  = 1'b1;
        wr_en   = 1'b1;
        wr_data = pc_q + imm_u;
      end
      OPC_JAL: begin
        use_rd  = 1'b1;
        wr_en   = 1'b1;
        wr_data = pc_plus4;
        next_pc = pc_q + imm_j;
      end
      OPC_JALR: begin
        use_rd      = 1'b1;
        use_rs1     = 1'b1;
        wr_en       = 1'b1;
        wr_data     = pc_plus4;
        next_pc     = (rs1_val + imm_i) & ~32'd1;
        dec_illegal = (funct3 != 3'd0);
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        case (funct3)
          3'd0:    taken = (rs1_val == rs2_val);
          3'd1:    taken = (rs1_val != rs2_val);
          3'd4:    taken = ($signed(rs1_val) <  $signed(rs2_val));
          3'd5:    taken = ($signed(rs1_val) >= $signed(rs2_val));
          3'd6:    taken = (rs1_val <  rs2_val);
          3'd7:    taken = (rs1_val >= rs2_val);
          default: dec_illegal = 1'b1;
        endcase
        if (taken) next_pc = pc_q + imm_b;
      end
      OPC_LOAD: begin
        use_rd      = 1'b1;
        use_rs1     = 1'b1;
        is_mem      = 1'b1;
        dec_illegal = (funct3 != 3'd2);
      end
      OPC_STORE: begin
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        is_mem      = 1'b1;
        mem_we      = 1'b1;
        dec_illegal = (funct3 != 3'd2);
      end
      OPC_OPIMM: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        wr_en   = 1'b1;
        if (funct3 == 3'd1)
          dec_illegal = (funct7 != 7'b0000000);
        else if (funct3 == 3'd5)
          dec_illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OPC_OP: begin
        use_rd      = 1'b1;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        wr_en       = 1'b1;
        dec_illegal = !((funct7 == 7'b0000000) ||
                        (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5)));
      end
      OPC_SYSTEM: begin
        is_ebreak   = (ir_q == 32'h0010_0073);
        dec_illegal = !is_ebreak;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Untaken branches fall back to pc+4, which is always aligned
  assign exec_illegal = dec_illegal
                      | next_pc[1]
                      | (is_mem & (mem_addr[1:0] != 2'b00))
                      | (OOB_CHECK & ((use_rd & rd[4]) | (use_rs1 & rs1[4]) | (use_rs2 & rs2[4])));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= S_FETCH;
      pc_q             <= RESET_PC;
      ir_q             <= 32'd0;
      retire_q         <= 1'b0;
      halted_q         <= 1'b0;
      illegal_q        <= 1'b0;
      halt_code_q      <= 32'd0;
      imem_req_valid_q <= 1'b1;
      dmem_req_valid_q <= 1'b0;
      dmem_we_q        <= 1'b0;
      dmem_addr_q      <= 32'd0;
      dmem_wdata_q     <= 32'd0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 32'd0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (bus.imem_req_ready) begin
            imem_req_valid_q <= 1'b0;
            state_q          <= S_WAIT_I;
          end
        end
        S_WAIT_I: begin
          if (bus.imem_rsp_valid) begin
            ir_q    <= bus.imem_rdata;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exec_illegal) begin
            halted_q    <= 1'b1;
            illegal_q   <= 1'b1;
            halt_code_q <= regs_q[X10_IDX];
            state_q     <= S_HALT;
          end else if (is_ebreak) begin
            retire_q    <= 1'b1;
            halted_q    <= 1'b1;
            halt_code_q <= regs_q[X10_IDX];
            state_q     <= S_HALT;
          end else if (is_mem) begin
            dmem_req_valid_q <= 1'b1;
            dmem_we_q        <= mem_we;
            dmem_addr_q      <= mem_addr;
            dmem_wdata_q     <= rs2_val;
            state_q          <= S_MEM;
          end else begin
            if (wr_en && rd != 5'd0) regs_q[rd[RIDX_W-1:0]] <= wr_data;
            pc_q             <= next_pc;
            retire_q         <= 1'b1;
            imem_req_valid_q <= 1'b1;
            state_q          <= S_FETCH;
          end
        end
        S_MEM: begin
          if (bus.dmem_req_ready) begin
            dmem_req_valid_q <= 1'b0;
            if (dmem_we_q) begin
              pc_q             <= pc_plus4;
              retire_q         <= 1'b1;
              imem_req_valid_q <= 1'b1;
              state_q          <= S_FETCH;
            end else begin
              state_q <= S_WAIT_D;
            end
          end
        end
        S_WAIT_D: begin
          if (bus.dmem_rsp_valid) begin
            if (rd != 5'd0) regs_q[rd[RIDX_W-1:0]] <= bus.dmem_rdata;
            pc_q             <= pc_plus4;
            retire_q         <= 1'b1;
            imem_req_valid_q <= 1'b1;
            state_q          <= S_FETCH;
          end
        end
        S_HALT: begin
          imem_req_valid_q <= 1'b0;
        end
        default: begin
          halted_q         <= 1'b1;
          illegal_q        <= 1'b1;
          imem_req_valid_q <= 1'b0;
          state_q          <= S_HALT;
        end
      endcase
    end
  end

  assign bus.imem_req_valid = imem_req_valid_q;
  assign bus.imem_addr      = pc_q;
  assign bus.dmem_req_valid = dmem_req_valid_q;
  assign bus.dmem_we        = dmem_we_q;
  assign bus.dmem_addr      = dmem_addr_q;
  assign bus.dmem_wdata     = dmem_wdata_q;

  assign pc        = pc_q;
  assign retire    = retire_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign halt_code = halt_code_q;

endmodule

`default_nettype wire

// File: tb/tb_npc_multicycle_core.sv
// Bench for npc_multicycle_core: table of small programs against a memory
// responder, plus stall, reset-in-WAIT_D and RV32E register-range sequences.
`default_nettype none

module tb_npc_multicycle_core;
  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam int          NV  = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  npc_multicycle_core_if bus();
  npc_multicycle_core_if bus2();

  logic [31:0] pc, halt_code, pc2, halt_code2;
  logic        retire, halted, illegal, retire2, halted2, illegal2;

  npc_multicycle_core #(.RESET_PC(RPC), .NREGS(32)) dut (
    .clk(clk), .rstn(rstn), .bus(bus.master), .pc(pc), .retire(retire),
    .halted(halted), .illegal(illegal), .halt_code(halt_code));

  npc_multicycle_core #(.RESET_PC(RPC), .NREGS(16)) dut16 (
    .clk(clk), .rstn(rstn), .bus(bus2.master), .pc(pc2), .retire(retire2),
    .halted(halted2), .illegal(illegal2), .halt_code(halt_code2));

  // RV32E instance sees only "add x20,x0,x0"
  initial begin
    bus2.imem_req_ready = 1'b1;
    bus2.imem_rsp_valid = 1'b1;
    bus2.imem_rdata     = 32'h0000_0A33;
    bus2.dmem_req_ready = 1'b1;
    bus2.dmem_rsp_valid = 1'b0;
    bus2.dmem_rdata     = 32'd0;
  end

  // Controls written by the main sequence only
  logic [31:0] imem [64];
  int          stall_set, dmem_delay;
  bit          keep_pending;
  logic [31:0] load_data;

  // Observations written by the responder only
  int          istall, ret_count, ret2_count, ihs_count, dhs_count, dbl_count, late_seen;
  int          pend_cnt;
  bit          pending, prev_ret, p_ihs, p_dhs, p_dwe;
  logic [31:0] p_iaddr, p_daddr, p_dwdata, st_addr, st_data, off;

  initial begin
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rdata = 32'd0;
    bus.dmem_req_ready = 1'b1; bus.dmem_rsp_valid = 1'b0; bus.dmem_rdata = 32'd0;
    istall = 0; ret_count = 0; ret2_count = 0; ihs_count = 0; dhs_count = 0;
    dbl_count = 0; late_seen = 0; pend_cnt = 0; pending = 0; prev_ret = 0;
    p_ihs = 0; p_dhs = 0; p_dwe = 0; p_iaddr = 0; p_daddr = 0; p_dwdata = 0;
    st_addr = 0; st_data = 0; off = 0;
    forever begin
      @(posedge clk); #1;
      if (!rstn) begin
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.dmem_rsp_valid = 1'b0;
        istall = stall_set; ret_count = 0; ret2_count = 0; ihs_count = 0; dhs_count = 0;
        dbl_count = 0; prev_ret = 0; st_addr = 0; st_data = 0;
        if (!keep_pending) pending = 0;
      end else begin
        bus.imem_rsp_valid = p_ihs;
        if (p_ihs) begin
          ihs_count++;
          off = p_iaddr - RPC;
          bus.imem_rdata = (off[31:8] == 24'd0) ? imem[off[7:2]] : 32'hFFFF_FFFF;
        end
        if (p_dhs) begin
          dhs_count++;
          if (p_dwe) begin st_addr = p_daddr; st_data = p_dwdata; end
          else begin pending = 1; pend_cnt = dmem_delay; end
        end
        if (istall > 0) begin bus.imem_req_ready = 1'b0; istall--; end
        else bus.imem_req_ready = 1'b1;
        if (retire) begin ret_count++; if (prev_ret) dbl_count++; end
        prev_ret = retire;
        if (retire2) ret2_count++;
      end
      bus.dmem_rsp_valid = 1'b0;
      if (pending) begin
        if (pend_cnt == 0) begin
          bus.dmem_rsp_valid = 1'b1; bus.dmem_rdata = load_data; pending = 0; late_seen++;
        end else pend_cnt--;
      end
      p_ihs    = bus.imem_req_valid && bus.imem_req_ready;
      p_iaddr  = bus.imem_addr;
      p_dhs    = bus.dmem_req_valid && bus.dmem_req_ready;
      p_dwe    = bus.dmem_we;
      p_daddr  = bus.dmem_addr;
      p_dwdata = bus.dmem_wdata;
    end
  end

  typedef struct packed {
    logic [7:0]  dly;
    logic [31:0] ldata;
    logic [7:0]  exp_ret;
    logic        exp_ill;
    logic [31:0] exp_code;
    logic [31:0] exp_pc;
    logic [7:0]  exp_dhs;
    logic [31:0] exp_sa;
    logic [31:0] exp_sd;
  } vec_t;

  vec_t        vt    [NV];
  logic [31:0] progs [NV][8];
  string       names [NV];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic load_prog(input int k);
    for (int j = 0; j < 64; j++) imem[j] = (j < 8) ? progs[k][j] : 32'hFFFF_FFFF;
  endtask

  task automatic do_reset();
    @(negedge clk); rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_halt(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (halted) begin ok = 1'b1; break; end
    end
  endtask

  bit ok;
  int saved;

  initial begin
    rstn = 1'b0; stall_set = 0; dmem_delay = 0; keep_pending = 0; load_data = 32'd0;
    for (int j = 0; j < 64; j++) imem[j] = 32'hFFFF_FFFF;
    for (int k = 0; k < NV; k++) for (int j = 0; j < 8; j++) progs[k][j] = 32'hFFFF_FFFF;

    names[0] = "addi_add_ebreak";
    progs[0][0] = 32'h0050_0513; progs[0][1] = 32'h00A5_0533; progs[0][2] = 32'h0010_0073;
    vt[0] = '{8'd0, 32'd0, 8'd3, 1'b0, 32'd10, 32'h8000_0008, 8'd0, 32'd0, 32'd0};

    names[1] = "sw_lw";
    progs[1][0] = 32'h8000_12B7; progs[1][1] = 32'h0550_0313; progs[1][2] = 32'h0062_A023;
    progs[1][3] = 32'h0002_A503; progs[1][4] = 32'h0010_0073;
    vt[1] = '{8'd2, 32'hDEAD_BEEF, 8'd5, 1'b0, 32'hDEAD_BEEF, 32'h8000_0010, 8'd2,
              32'h8000_1000, 32'h0000_0055};

    names[2] = "countdown";
    progs[2][0] = 32'h0030_0513; progs[2][1] = 32'hFFF5_0513; progs[2][2] = 32'hFE05_1EE3;
    progs[2][3] = 32'h0010_0073;
    vt[2] = '{8'd0, 32'd0, 8'd8, 1'b0, 32'd0, 32'h8000_000C, 8'd0, 32'd0, 32'd0};

    names[3] = "jal_jalr";
    progs[3][0] = 32'h0080_00EF; progs[3][2] = 32'h0080_8067; progs[3][3] = 32'h0000_8513;
    progs[3][4] = 32'h0010_0073;
    vt[3] = '{8'd0, 32'd0, 8'd4, 1'b0, 32'h8000_0004, 32'h8000_0010, 8'd0, 32'd0, 32'd0};

    names[4] = "srai_slt_sub";
    progs[4][0] = 32'hFF80_0093; progs[4][1] = 32'h4010_D113; progs[4][2] = 32'h0000_A1B3;
    progs[4][3] = 32'h4031_0533; progs[4][4] = 32'h0010_0073;
    vt[4] = '{8'd0, 32'd0, 8'd5, 1'b0, 32'hFFFF_FFFB, 32'h8000_0010, 8'd0, 32'd0, 32'd0};

    names[5] = "misaligned_lw";
    progs[5][0] = 32'h0020_0293; progs[5][1] = 32'h0002_A503;
    vt[5] = '{8'd0, 32'd0, 8'd1, 1'b1, 32'd0, 32'h8000_0004, 8'd0, 32'd0, 32'd0};

    names[6] = "illegal_word";
    vt[6] = '{8'd0, 32'd0, 8'd0, 1'b1, 32'd0, 32'h8000_0000, 8'd0, 32'd0, 32'd0};

    names[7] = "misaligned_beq";
    progs[7][0] = 32'h0000_0163;
    vt[7] = '{8'd0, 32'd0, 8'd0, 1'b1, 32'd0, 32'h8000_0000, 8'd0, 32'd0, 32'd0};

    // Reset values, then first fetch held off for several cycles
    load_prog(0);
    stall_set = 4;
    do_reset();
    @(negedge clk);
    check("rst_imem_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    check("rst_imem_addr",  bus.imem_addr, RPC);
    check("rst_halted",     {31'd0, halted}, 32'd0);
    check("rst_retire",     {31'd0, retire}, 32'd0);
    check("rst_dmem_valid", {31'd0, bus.dmem_req_valid}, 32'd0);
    check("rst_halt_code",  halt_code, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_addr",   bus.imem_addr, RPC);
      check("stall_valid",  {31'd0, bus.imem_req_valid}, 32'd1);
      check("stall_retire", {31'd0, retire}, 32'd0);
    end
    wait_halt(200, ok);
    check("stall_done",      {31'd0, ok}, 32'd1);
    check("stall_retires",   ret_count, 32'd3);
    check("stall_halt_code", halt_code, 32'd10);
    stall_set = 0;

    for (int k = 0; k < NV; k++) begin
      load_prog(k);
      dmem_delay = int'(vt[k].dly);
      load_data  = vt[k].ldata;
      do_reset();
      wait_halt(400, ok);
      check({names[k], "_halt_timeout"}, {31'd0, ok}, 32'd1);
      saved = ihs_count;
      repeat (5) @(negedge clk);
      check({names[k], "_halted"},    {31'd0, halted}, 32'd1);
      check({names[k], "_illegal"},   {31'd0, illegal}, {31'd0, vt[k].exp_ill});
      check({names[k], "_retires"},   ret_count, {24'd0, vt[k].exp_ret});
      check({names[k], "_halt_code"}, halt_code, vt[k].exp_code);
      check({names[k], "_pc"},        pc, vt[k].exp_pc);
      check({names[k], "_dmem_reqs"}, dhs_count, {24'd0, vt[k].exp_dhs});
      check({names[k], "_st_addr"},   st_addr, vt[k].exp_sa);
      check({names[k], "_st_data"},   st_data, vt[k].exp_sd);
      check({names[k], "_post_halt_fetch"}, ihs_count - saved, 32'd0);
      check({names[k], "_retire_back2back"}, dbl_count, 32'd0);
      check({names[k], "_imem_valid_halt"}, {31'd0, bus.imem_req_valid}, 32'd0);
    end

    // Reset while waiting on a slow load; its response lands after reset
    load_prog(1);
    dmem_delay = 20; load_data = 32'hDEAD_BEEF; keep_pending = 1'b0;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dhs_count == 2) begin ok = 1'b1; break; end
    end
    check("waitd_reached", {31'd0, ok}, 32'd1);
    stall_set = 30; keep_pending = 1'b1; saved = late_seen;
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    check("waitd_rst_dmem_valid", {31'd0, bus.dmem_req_valid}, 32'd0);
    check("waitd_rst_retire",     {31'd0, retire}, 32'd0);
    check("waitd_rst_pc",         pc, RPC);
    check("waitd_rst_imem_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    dmem_delay = 0;
    repeat (25) @(negedge clk);
    check("late_rsp_driven",  late_seen - saved, 32'd1);
    check("late_rsp_retires", ret_count, 32'd0);
    check("late_rsp_pc",      pc, RPC);
    check("late_rsp_halted",  {31'd0, halted}, 32'd0);
    keep_pending = 1'b0;
    wait_halt(300, ok);
    check("after_rst_halt",    {31'd0, ok}, 32'd1);
    check("after_rst_code",    halt_code, 32'hDEAD_BEEF);
    check("after_rst_retires", ret_count, 32'd5);
    stall_set = 0;

    // RV32E instance: x20 is out of range
    check("rv32e_halted",  {31'd0, halted2}, 32'd1);
    check("rv32e_illegal", {31'd0, illegal2}, 32'd1);
    check("rv32e_retires", ret2_count, 32'd0);
    check("rv32e_pc",      pc2, RPC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
